ks_pluck_ctrl: RTL and testbench

Note-request controller for the Karplus-Strong string voice. It arbitrates note-on requests from two sources: the host port (0) and the pattern step sequencer (1). For each accepted request it sequences the string: load the period, drive a clean pluck pulse, then hold off new notes until the noise burst and a guard interval have finished. It also gates the string's freeze control, so the delay line is never frozen while a burst is being written.

---
 rtl/ks_pluck_ctrl.sv | 158 +++++++++++++++
 tb/tb_ks_pluck_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_pluck_ctrl.sv
// ks_pluck_ctrl: note-request controller for the Karplus-Strong string voice.
// Arbitrates note-on requests from the host (source 0) and the step sequencer
// (source 1). Each accepted note is sequenced as:
//   LOAD (period settles) -> PLUCK (clean pluck pulse) -> BURST (period + guard).
// freeze_o is gated off while a note is in progress, so the delay line is never
// frozen while a burst is being written.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   req0_valid_i/period_i/ready_o  host request handshake
//   req1_valid_i/period_i/ready_o  sequencer request handshake
//   rr_mode_i                      0 = req0 priority, 1 = round robin
//   hold_i                         host freeze request (honoured only in IDLE)
//   abort_i                        terminate the current note early
//   period_o, pluck_o, freeze_o    string controls
//   busy_o                         note in progress
//   grant_id_o                     source of the current or last note
//   note_done_o                    one-cycle pulse at note end or abort
module ks_pluck_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_LENGTH     = 256,
  parameter int unsigned PLUCK_HOLD     = 4,
  parameter int unsigned GUARD          = 4,
  parameter int unsigned DEFAULT_PERIOD = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic [DATA_WIDTH-1:0] req0_period_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [DATA_WIDTH-1:0] req1_period_i,
  output logic                  req1_ready_o,
  input  logic                  rr_mode_i,
  input  logic                  hold_i,
  input  logic                  abort_i,
  output logic [DATA_WIDTH-1:0] period_o,
  output logic                  pluck_o,
  output logic                  freeze_o,
  output logic                  busy_o,
  output logic                  grant_id_o,
  output logic                  note_done_o
);

  localparam int unsigned CNT_W = $clog2(MAX_LENGTH + GUARD) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StPluck, StBurst} state_e;

  state_e                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [DATA_WIDTH-1:0] r_period, w_period_next;
  logic                  r_grant, w_grant_next;
  logic                  r_last, w_last_next;
  logic                  r_done, w_done_next;
  logic                  r_freeze, w_freeze_next;

  logic                  w_idle;
  logic                  w_sel;
  logic                  w_hs;
  logic [DATA_WIDTH-1:0] w_req_period;
  logic [DATA_WIDTH-1:0] w_clamped;

  assign w_idle = (r_state == StIdle);

  // Source select: round robin only matters under contention; otherwise the
  // single valid source (or req0 in fixed mode) wins.
  assign w_sel        = (rr_mode_i && req0_valid_i && req1_valid_i) ? ~r_last : ~req0_valid_i;
  assign req0_ready_o = w_idle && req0_valid_i && !w_sel;
  assign req1_ready_o = w_idle && req1_valid_i && w_sel;
  assign w_hs         = req0_ready_o || req1_ready_o;
  assign w_req_period = w_sel ? req1_period_i : req0_period_i;

  always_comb begin
    w_clamped = w_req_period;
    if (32'(w_req_period) < 32'd2) begin
      w_clamped = DATA_WIDTH'(2);
    end else if (32'(w_req_period) > MAX_LENGTH) begin
      w_clamped = DATA_WIDTH'(MAX_LENGTH);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_period_next = r_period;
    w_grant_next  = r_grant;
    w_last_next   = r_last;
    w_done_next   = 1'b0;
    // Freeze follows hold only while staying idle; a starting note forces it low.
    w_freeze_next = w_idle && !w_hs && hold_i;

    unique case (r_state)
      StIdle: begin
        if (w_hs) begin
          w_state_next  = StLoad;
          w_period_next = w_clamped;
          w_grant_next  = w_sel;
          w_last_next   = w_sel;
        end
      end
      StLoad: begin
        w_state_next = StPluck;
        w_cnt_next   = CNT_W'(PLUCK_HOLD - 1);
      end
      StPluck: begin
        if (r_cnt == '0) begin
          w_state_next = StBurst;
          w_cnt_next   = CNT_W'(r_period) + CNT_W'(GUARD - 1);
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StBurst: begin
        if (r_cnt == '0) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (!w_idle && abort_i) begin
      w_state_next = StIdle;
      w_cnt_next   = '0;
      w_done_next  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_period <= DATA_WIDTH'(DEFAULT_PERIOD);
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_done   <= 1'b0;
      r_freeze <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_period <= w_period_next;
      r_grant  <= w_grant_next;
      r_last   <= w_last_next;
      r_done   <= w_done_next;
      r_freeze <= w_freeze_next;
    end
  end

  assign period_o    = r_period;
  assign pluck_o     = (r_state == StPluck);
  assign busy_o      = !w_idle;
  assign freeze_o    = r_freeze;
  assign grant_id_o  = r_grant;
  assign note_done_o = r_done;

endmodule

// File: tb/tb_ks_pluck_ctrl.sv
// Bench for ks_pluck_ctrl: a cycle-offset model (time since handshake decides
// each output) checked on every falling edge, plus directed literal checks.
module tb_ks_pluck_ctrl;

  localparam int DW  = 8;
  localparam int MAX = 256;
  localparam int PH  = 4;
  localparam int G   = 4;
  localparam int DEF = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [DW-1:0] req0_period_i = '0, req1_period_i = '0;
  logic          rr_mode_i = 1'b0, hold_i = 1'b0, abort_i = 1'b0;
  logic          req0_ready_o, req1_ready_o;
  logic [DW-1:0] period_o;
  logic          pluck_o, freeze_o, busy_o, grant_id_o, note_done_o;

  ks_pluck_ctrl #(
    .DATA_WIDTH(DW), .MAX_LENGTH(MAX), .PLUCK_HOLD(PH), .GUARD(G), .DEFAULT_PERIOD(DEF)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid_i), .req0_period_i(req0_period_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_period_i(req1_period_i), .req1_ready_o(req1_ready_o),
    .rr_mode_i(rr_mode_i), .hold_i(hold_i), .abort_i(abort_i),
    .period_o(period_o), .pluck_o(pluck_o), .freeze_o(freeze_o), .busy_o(busy_o),
    .grant_id_o(grant_id_o), .note_done_o(note_done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  // A note is described only by k = cycles since its handshake (k=1 first busy
  // cycle) and its clamped period p; it lasts 1 + PH + p + G busy cycles.
  int m_busy, m_k, m_p, m_period, m_grant, m_last, m_done, m_freeze;
  int m_win, m_rdy0, m_rdy1, m_hs, m_req_p, m_clamp, m_pluck;

  always_comb begin
    m_win = 0;
    m_rdy0 = 0;
    m_rdy1 = 0;
    if (req0_valid_i && req1_valid_i) m_win = (rr_mode_i && m_last == 0) ? 1 : 0;
    else if (req1_valid_i) m_win = 1;
    if (m_busy == 0) begin
      m_rdy0 = (req0_valid_i && m_win == 0) ? 1 : 0;
      m_rdy1 = (req1_valid_i && m_win == 1) ? 1 : 0;
    end
    m_hs    = m_rdy0 | m_rdy1;
    m_req_p = (m_win == 1) ? int'(req1_period_i) : int'(req0_period_i);
    m_clamp = (m_req_p < 2) ? 2 : ((m_req_p > MAX) ? MAX : m_req_p);
    m_pluck = (m_busy == 1 && m_k >= 2 && m_k <= PH + 1) ? 1 : 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_k <= 0; m_p <= 0; m_period <= DEF;
      m_grant <= 0; m_last <= 1; m_done <= 0; m_freeze <= 0;
    end else begin
      m_freeze <= (m_busy == 0 && m_hs == 0) ? int'(hold_i) : 0;
      if (m_busy == 1) begin
        if (abort_i || m_k == 1 + PH + m_p + G) begin
          m_busy <= 0;
          m_done <= 1;
        end else begin
          m_k    <= m_k + 1;
          m_done <= 0;
        end
      end else begin
        m_done <= 0;
        if (m_hs == 1) begin
          m_busy <= 1; m_k <= 1; m_p <= m_clamp; m_period <= m_clamp;
          m_grant <= m_win; m_last <= m_win;
        end
      end
    end
  end

  // Single compare process against the model.
  always @(negedge clk) begin
    chk("req0_ready", int'(req0_ready_o), m_rdy0);
    chk("req1_ready", int'(req1_ready_o), m_rdy1);
    chk("period",     int'(period_o),     m_period);
    chk("pluck",      int'(pluck_o),      m_pluck);
    chk("freeze",     int'(freeze_o),     m_freeze);
    chk("busy",       int'(busy_o),       m_busy);
    chk("grant_id",   int'(grant_id_o),   m_grant);
    chk("note_done",  int'(note_done_o),  m_done);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_busy(input logic lvl, input int max);
    for (int n = 0; n < max && busy_o !== lvl; n++) tick();
    chk("wait busy level", int'(busy_o), int'(lvl));
  endtask

  // Issue one uncontended request from IDLE and check its literal timing.
  task automatic run_note(input bit src, input int per, input int exp_per, input int exp_len);
    int t0;
    int np;
    np = 0;
    if (src) begin
      req1_valid_i = 1'b1; req1_period_i = 8'(per);
    end else begin
      req0_valid_i = 1'b1; req0_period_i = 8'(per);
    end
    tick();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    t0 = cyc;
    chk("load period", int'(period_o), exp_per);
    chk("load grant", int'(grant_id_o), int'(src));
    chk("load busy", int'(busy_o), 1);
    for (int n = 0; n < 400 && !note_done_o; n++) begin
      tick();
      if (pluck_o) np++;
    end
    chk("done seen", int'(note_done_o), 1);
    chk("note length", cyc - t0, exp_len);
    chk("pluck cycles", np, PH);
    chk("idle at done", int'(busy_o), 0);
  endtask

  int t_start;
  int saw_r1;

  initial begin
    tick();
    tick();
    chk("reset period", int'(period_o), DEF);
    chk("reset busy", int'(busy_o), 0);
    chk("reset grant", int'(grant_id_o), 0);
    chk("reset freeze", int'(freeze_o), 0);
    rst = 1'b0;
    tick();

    // Basic note, period 10: 1 + 4 + 10 + 4 busy cycles.
    run_note(1'b0, 10, 10, 19);
    tick();

    // Round robin with both sources held valid.
    do_reset();
    rr_mode_i = 1'b1;
    req0_valid_i = 1'b1; req0_period_i = 8'd5;
    req1_valid_i = 1'b1; req1_period_i = 8'd7;
    for (int i = 0; i < 4; i++) begin
      wait_busy(1'b1, 40);
      t_start = cyc;
      chk("rr grant", int'(grant_id_o), i % 2);
      wait_busy(1'b0, 40);
      chk("rr note length", cyc - t_start, (i % 2 == 1) ? 16 : 14);
    end
    // Fixed priority: req0 always wins.
    rr_mode_i = 1'b0;
    saw_r1 = 0;
    for (int i = 0; i < 3; i++) begin
      if (req1_ready_o) saw_r1 = 1;
      wait_busy(1'b1, 40);
      t_start = cyc;
      chk("fixed grant", int'(grant_id_o), 0);
      for (int n = 0; n < 40 && busy_o; n++) begin
        tick();
        if (req1_ready_o) saw_r1 = 1;
      end
      chk("fixed note length", cyc - t_start, 14);
    end
    chk("req1 ready in fixed", saw_r1, 0);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    tick();

    // Period clamp.
    run_note(1'b1, 0, 2, 11);
    run_note(1'b0, 1, 2, 11);
    run_note(1'b1, 255, 255, 264);
    tick();

    // Freeze gating.
    hold_i = 1'b1;
    tick();
    tick();
    chk("freeze idle", int'(freeze_o), 1);
    req0_valid_i = 1'b1; req0_period_i = 8'd3;
    tick();
    req0_valid_i = 1'b0;
    chk("freeze load", int'(freeze_o), 0);
    wait_busy(1'b0, 40);
    chk("freeze first idle", int'(freeze_o), 0);
    tick();
    chk("freeze after idle", int'(freeze_o), 1);
    hold_i = 1'b0;
    tick();
    chk("freeze released", int'(freeze_o), 0);

    // Abort on the 3rd pluck cycle with req1 pending.
    req0_valid_i = 1'b1; req0_period_i = 8'd10;
    tick();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_period_i = 8'd20;
    tick();
    tick();
    tick();
    chk("pluck before abort", int'(pluck_o), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort pluck", int'(pluck_o), 0);
    chk("abort done", int'(note_done_o), 1);
    chk("abort idle", int'(busy_o), 0);
    chk("abort req1 ready", int'(req1_ready_o), 1);
    tick();
    req1_valid_i = 1'b0;
    chk("post-abort grant", int'(grant_id_o), 1);
    chk("post-abort period", int'(period_o), 20);
    wait_busy(1'b0, 40);
    tick();

    // Asynchronous reset mid-burst.
    req0_valid_i = 1'b1; req0_period_i = 8'd50;
    tick();
    req0_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst period", int'(period_o), DEF);
    chk("rst busy", int'(busy_o), 0);
    chk("rst pluck", int'(pluck_o), 0);
    chk("rst freeze", int'(freeze_o), 0);
    chk("rst grant", int'(grant_id_o), 0);
    chk("rst done", int'(note_done_o), 0);
    tick();
    rst = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
